mm_ctrl: RTL and testbench

Matching-memory controller for the MMRAM stage of the data-driven pipeline. Accepts tokens from the upstream firing stage, keeps a 64-entry presence/side table that mirrors the waiting-operand RAM, and drives the stage's `WR_E`, `DEL` and `ADDR` per token. First operands are parked with the token deleted; second operands read the partner and continue; non-matching tokens pass through. Also clears the table after reset or on flush.

---
 rtl/mm_ctrl_pkg.sv | 50 +++++
 rtl/mm_ctrl_if.sv | 28 ++
 rtl/mm_presence_tbl.sv | 36 +++
 rtl/mm_ctrl.sv | 167 ++++++++++++++++
 tb/tb_mm_ctrl.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/mm_ctrl_pkg.sv
// Shared constants, token field positions and encodings for the matching-memory controller.
// Imported by the interface, the presence table and the controller top.
package mm_ctrl_pkg;

    localparam int DEPTH  = 64;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PKT_W  = 38;
    localparam int OCC_W  = ADDR_W + 1;

    // Token layout: {color/gen[37:27], dest[26:20], LR[19], MF[18], C/Z[17:16], data[15:0]}
    localparam int CGD_MSB  = 37;
    localparam int CGD_LSB  = 20;
    localparam int DEST_MSB = 26;
    localparam int DEST_LSB = 20;
    localparam int LR_BIT   = 19;
    localparam int MF_BIT   = 18;
    localparam int CZ_MSB   = 17;
    localparam int CZ_LSB   = 16;
    localparam int DATA_MSB = 15;
    localparam int DATA_LSB = 0;

    typedef enum logic [1:0] {
        ST_INIT       = 2'd0,
        ST_RUN        = 2'd1,
        ST_FLUSH_WAIT = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        ACT_PASS  = 2'd0,
        ACT_PARK  = 2'd1,
        ACT_MATCH = 2'd2,
        ACT_COLL  = 2'd3
    } action_e;

    function automatic logic [ADDR_W-1:0] pkt_addr(input logic [PKT_W-1:0] pkt);
        return pkt[DEST_LSB +: ADDR_W];
    endfunction

    // Decides what the RAM stage does with a token given the entry it addresses.
    function automatic action_e classify(input logic mf, input logic present,
                                         input logic side, input logic lr);
        action_e act;
        if (!mf)               act = ACT_PASS;
        else if (!present)     act = ACT_PARK;
        else if (side != lr)   act = ACT_MATCH;
        else                   act = ACT_COLL;
        return act;
    endfunction

endpackage

// File: rtl/mm_ctrl_if.sv
// Token and stage-issue bus of the matching-memory controller.
// Both channels are valid/ready: a transfer happens on a rising CP edge where valid and
// ready are both high; once valid is raised, the payload holds until that transfer.
interface mm_ctrl_if;
    import mm_ctrl_pkg::*;

    logic              tok_valid;
    logic              tok_ready;
    logic [PKT_W-1:0]  tok_pkt;

    logic              st_valid;
    logic              st_ready;
    logic [PKT_W-1:0]  st_pkt;
    logic              WR_E;
    logic              DEL;
    logic [ADDR_W-1:0] ADDR;

    modport master (
        output tok_valid, tok_pkt, st_ready,
        input  tok_ready, st_valid, st_pkt, WR_E, DEL, ADDR
    );

    modport slave (
        input  tok_valid, tok_pkt, st_ready,
        output tok_ready, st_valid, st_pkt, WR_E, DEL, ADDR
    );

endinterface

// File: rtl/mm_presence_tbl.sv
// Presence/side flags mirroring the waiting-operand RAM: one combinational read port,
// one write port that sets or clears an entry, and a sweep port that clears one entry.
module mm_presence_tbl
    import mm_ctrl_pkg::*;
(
    input  logic              CP,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic              o_rd_present,
    output logic              o_rd_side,
    input  logic              i_wr_en,
    input  logic              i_wr_set,
    input  logic              i_wr_side,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic              i_clr_en,
    input  logic [ADDR_W-1:0] i_clr_addr
);

    logic [DEPTH-1:0] r_present;
    logic [DEPTH-1:0] r_side;

    // No reset here: the controller's INIT sweep is what brings the table to a known state.
    always_ff @(posedge CP) begin
        if (i_clr_en) begin
            r_present[i_clr_addr] <= 1'b0;
        end else if (i_wr_en) begin
            r_present[i_wr_addr] <= i_wr_set;
            if (i_wr_set) begin
                r_side[i_wr_addr] <= i_wr_side;
            end
        end
    end

    assign o_rd_present = r_present[i_rd_addr];
    assign o_rd_side    = r_side[i_rd_addr];

endmodule

// File: rtl/mm_ctrl.sv
// Matching-memory controller: classifies each token against the presence table and issues
// it to the MMRAM stage with WR_E/DEL/ADDR one cycle later; sweeps the table after reset/flush.
module mm_ctrl
    import mm_ctrl_pkg::*;
(
    input  logic             CP,
    input  logic             MR,
    mm_ctrl_if.slave         bus,
    input  logic             flush,
    output logic [OCC_W-1:0] occupancy,
    output logic             collision,
    output logic             busy,
    output state_e           o_dbg_state
);

    state_e            r_state;
    state_e            w_next_state;
    logic [ADDR_W-1:0] r_sweep;

    logic              r_st_valid;
    logic [PKT_W-1:0]  r_st_pkt;
    logic              r_wr_e;
    logic              r_del;
    logic [ADDR_W-1:0] r_addr;
    logic [OCC_W-1:0]  r_occupancy;
    logic              r_collision;

    logic              w_tok_ready;
    logic              w_busy;
    logic              w_sweep_en;
    logic              w_accept;
    logic              w_leave_flush;
    logic [ADDR_W-1:0] w_tok_addr;
    logic              w_rd_present;
    logic              w_rd_side;
    action_e           w_action;
    logic              w_tbl_wr_en;

    // ---------------- FSM ----------------
    always_ff @(posedge CP) begin
        if (MR) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_tok_ready  = 1'b0;
        w_busy       = 1'b0;
        w_sweep_en   = 1'b0;
        unique case (r_state)
            ST_INIT: begin
                w_busy     = 1'b1;
                w_sweep_en = 1'b1;
                if (r_sweep == ADDR_W'(DEPTH - 1)) begin
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                w_tok_ready = !flush && (!r_st_valid || bus.st_ready);
                if (flush) begin
                    w_next_state = ST_FLUSH_WAIT;
                end
            end
            ST_FLUSH_WAIT: begin
                w_busy = 1'b1;
                // The parked issue must leave the output register before the sweep starts.
                if (!r_st_valid) begin
                    w_next_state = ST_INIT;
                end
            end
            default: begin
                w_next_state = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge CP) begin
        if (MR || !w_sweep_en) begin
            r_sweep <= '0;
        end else begin
            r_sweep <= r_sweep + 1'b1;
        end
    end

    // ---------------- classification ----------------
    assign w_accept      = bus.tok_valid && w_tok_ready;
    assign w_tok_addr    = pkt_addr(bus.tok_pkt);
    assign w_action      = classify(bus.tok_pkt[MF_BIT], w_rd_present, w_rd_side,
                                    bus.tok_pkt[LR_BIT]);
    assign w_tbl_wr_en   = w_accept && (w_action == ACT_PARK || w_action == ACT_MATCH);
    assign w_leave_flush = (r_state == ST_FLUSH_WAIT) && (w_next_state == ST_INIT);

    mm_presence_tbl u_tbl (
        .CP           (CP),
        .i_rd_addr    (w_tok_addr),
        .o_rd_present (w_rd_present),
        .o_rd_side    (w_rd_side),
        .i_wr_en      (w_tbl_wr_en),
        .i_wr_set     (w_action == ACT_PARK),
        .i_wr_side    (bus.tok_pkt[LR_BIT]),
        .i_wr_addr    (w_tok_addr),
        .i_clr_en     (w_sweep_en && !MR),
        .i_clr_addr   (r_sweep)
    );

    // ---------------- issue register ----------------
    always_ff @(posedge CP) begin
        if (MR) begin
            r_st_valid <= 1'b0;
            r_st_pkt   <= '0;
            r_wr_e     <= 1'b0;
            r_del      <= 1'b0;
            r_addr     <= '0;
        end else if (w_accept) begin
            r_st_valid <= 1'b1;
            r_st_pkt   <= bus.tok_pkt;
            r_wr_e     <= (w_action == ACT_PARK);
            r_del      <= (w_action == ACT_PARK) || (w_action == ACT_COLL);
            r_addr     <= w_tok_addr;
        end else if (bus.st_ready) begin
            // WR_E/DEL only mean something alongside st_valid, so drop them with it.
            r_st_valid <= 1'b0;
            r_wr_e     <= 1'b0;
            r_del      <= 1'b0;
        end
    end

    // ---------------- occupancy / collision ----------------
    always_ff @(posedge CP) begin
        if (MR) begin
            r_occupancy <= '0;
            r_collision <= 1'b0;
        end else if (w_leave_flush) begin
            r_occupancy <= '0;
            r_collision <= 1'b0;
        end else if (w_accept) begin
            unique case (w_action)
                ACT_PARK:  r_occupancy <= r_occupancy + OCC_W'(1);
                ACT_MATCH: r_occupancy <= r_occupancy - OCC_W'(1);
                ACT_COLL:  r_collision <= 1'b1;
                default:   ;
            endcase
        end
    end

    a_no_underflow: assert property (@(posedge CP) disable iff (MR)
        !(w_accept && w_action == ACT_MATCH && r_occupancy == '0));

    a_no_overflow: assert property (@(posedge CP) disable iff (MR)
        r_occupancy <= OCC_W'(DEPTH));

    // ---------------- outputs ----------------
    assign bus.tok_ready = w_tok_ready;
    assign bus.st_valid  = r_st_valid;
    assign bus.st_pkt    = r_st_pkt;
    assign bus.WR_E      = r_wr_e;
    assign bus.DEL       = r_del;
    assign bus.ADDR      = r_addr;
    assign occupancy     = r_occupancy;
    assign collision     = r_collision;
    assign busy          = w_busy;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_mm_ctrl.sv
// Directed bench for mm_ctrl: reset/INIT sweep, park/match, collision, stall, flush and
// mid-operation reset, each scenario checking hand-computed values inline.
module tb_mm_ctrl;
    import mm_ctrl_pkg::*;

    logic             CP;
    logic             MR;
    logic             flush;
    logic [OCC_W-1:0] occupancy;
    logic             collision;
    logic             busy;
    state_e           dbg_state;

    int errors = 0;
    int checks = 0;

    mm_ctrl_if bus();

    mm_ctrl dut (
        .CP          (CP),
        .MR          (MR),
        .bus         (bus.slave),
        .flush       (flush),
        .occupancy   (occupancy),
        .collision   (collision),
        .busy        (busy),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial CP = 1'b0;
    always #5 CP = ~CP;

    // ---------------- driver helpers ----------------
    function automatic logic [PKT_W-1:0] mk(input logic [10:0] cg, input logic [6:0] dest,
                                            input logic lr, input logic mf,
                                            input logic [1:0] cz, input logic [15:0] data);
        return {cg, dest, lr, mf, cz, data};
    endfunction

    task automatic tick();
        @(posedge CP);
        #1;
    endtask

    // Offer one token and return just after the edge that accepted it.
    task automatic send(input logic [PKT_W-1:0] pkt, input string name);
        bit done = 0;
        bus.tok_valid = 1'b1;
        bus.tok_pkt   = pkt;
        for (int i = 0; i < 200 && !done; i++) begin
            #1;
            if (bus.tok_ready === 1'b1) done = 1;
            @(posedge CP);
            #1;
        end
        bus.tok_valid = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_accept: got no accept expected accept within 200 cycles", name);
        end
    endtask

    task automatic drain();
        bus.tok_valid = 1'b0;
        bus.st_ready  = 1'b1;
        tick();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [PKT_W-1:0] pkt;
        int waited;
        pkt = mk(11'h2a, 7'd10, 1'b0, 1'b0, 2'b01, 16'hbeef);
        MR = 1'b1;
        flush = 1'b0;
        bus.st_ready  = 1'b1;
        bus.tok_valid = 1'b1;
        bus.tok_pkt   = pkt;
        tick();
        checks++; if (bus.st_valid !== 1'b0) begin errors++; $display("FAIL rst_st_valid: got %0b expected 0", bus.st_valid); end
        checks++; if (bus.WR_E !== 1'b0) begin errors++; $display("FAIL rst_wr_e: got %0b expected 0", bus.WR_E); end
        checks++; if (bus.DEL !== 1'b0) begin errors++; $display("FAIL rst_del: got %0b expected 0", bus.DEL); end
        checks++; if (bus.ADDR !== 6'd0) begin errors++; $display("FAIL rst_addr: got %0d expected 0", bus.ADDR); end
        checks++; if (bus.st_pkt !== 38'd0) begin errors++; $display("FAIL rst_st_pkt: got %0h expected 0", bus.st_pkt); end
        checks++; if (occupancy !== 7'd0) begin errors++; $display("FAIL rst_occupancy: got %0d expected 0", occupancy); end
        checks++; if (collision !== 1'b0) begin errors++; $display("FAIL rst_collision: got %0b expected 0", collision); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy: got %0b expected 1", busy); end
        checks++; if (bus.tok_ready !== 1'b0) begin errors++; $display("FAIL rst_tok_ready: got %0b expected 0", bus.tok_ready); end
        checks++; if (dbg_state !== ST_INIT) begin errors++; $display("FAIL rst_state: got %0d expected %0d", dbg_state, ST_INIT); end
        MR = 1'b0;
        #1;
        waited = 0;
        while (bus.tok_ready !== 1'b1 && waited < 200) begin
            tick();
            waited++;
        end
        checks++; if (waited !== 64) begin errors++; $display("FAIL init_not_ready_cycles: got %0d expected 64", waited); end
        tick();
        bus.tok_valid = 1'b0;
        checks++; if (bus.st_valid !== 1'b1) begin errors++; $display("FAIL first_accept_valid: got %0b expected 1", bus.st_valid); end
        checks++; if (bus.st_pkt !== pkt) begin errors++; $display("FAIL first_accept_pkt: got %0h expected %0h", bus.st_pkt, pkt); end
        checks++; if (bus.ADDR !== 6'd10) begin errors++; $display("FAIL first_accept_addr: got %0d expected 10", bus.ADDR); end
        checks++; if ({bus.WR_E, bus.DEL} !== 2'b00) begin errors++; $display("FAIL first_accept_wr_del: got %b expected 00", {bus.WR_E, bus.DEL}); end
        checks++; if (occupancy !== 7'd0) begin errors++; $display("FAIL first_accept_occ: got %0d expected 0", occupancy); end
        tick();
        checks++; if (bus.st_valid !== 1'b0) begin errors++; $display("FAIL first_drain_valid: got %0b expected 0", bus.st_valid); end
    endtask

    task automatic test_match();
        drain();
        send(mk(11'h001, 7'd5, 1'b0, 1'b1, 2'b00, 16'h0011), "match_first");
        checks++; if ({bus.st_valid, bus.WR_E, bus.DEL} !== 3'b111) begin errors++; $display("FAIL park_v_wr_del: got %b expected 111", {bus.st_valid, bus.WR_E, bus.DEL}); end
        checks++; if (bus.ADDR !== 6'd5) begin errors++; $display("FAIL park_addr: got %0d expected 5", bus.ADDR); end
        checks++; if (occupancy !== 7'd1) begin errors++; $display("FAIL park_occ: got %0d expected 1", occupancy); end
        send(mk(11'h001, 7'd5, 1'b1, 1'b1, 2'b00, 16'h0022), "match_second");
        checks++; if ({bus.st_valid, bus.WR_E, bus.DEL} !== 3'b100) begin errors++; $display("FAIL match_v_wr_del: got %b expected 100", {bus.st_valid, bus.WR_E, bus.DEL}); end
        checks++; if (bus.ADDR !== 6'd5) begin errors++; $display("FAIL match_addr: got %0d expected 5", bus.ADDR); end
        checks++; if (occupancy !== 7'd0) begin errors++; $display("FAIL match_occ: got %0d expected 0", occupancy); end
        checks++; if (collision !== 1'b0) begin errors++; $display("FAIL match_no_coll: got %0b expected 0", collision); end
    endtask

    task automatic test_collision();
        drain();
        send(mk(11'h002, 7'd9, 1'b0, 1'b1, 2'b00, 16'h0900), "coll_first");
        checks++; if ({bus.WR_E, bus.DEL} !== 2'b11) begin errors++; $display("FAIL coll_park_wr_del: got %b expected 11", {bus.WR_E, bus.DEL}); end
        send(mk(11'h002, 7'd9, 1'b0, 1'b1, 2'b00, 16'h0901), "coll_second");
        checks++; if ({bus.st_valid, bus.WR_E, bus.DEL} !== 3'b101) begin errors++; $display("FAIL coll_v_wr_del: got %b expected 101", {bus.st_valid, bus.WR_E, bus.DEL}); end
        checks++; if (collision !== 1'b1) begin errors++; $display("FAIL coll_sticky: got %0b expected 1", collision); end
        checks++; if (occupancy !== 7'd1) begin errors++; $display("FAIL coll_occ: got %0d expected 1", occupancy); end
    endtask

    task automatic test_stall();
        logic [PKT_W-1:0] p0;
        logic [PKT_W-1:0] p1;
        p0 = mk(11'h003, 7'd3, 1'b0, 1'b0, 2'b10, 16'h1234);
        p1 = mk(11'h004, 7'd4, 1'b1, 1'b0, 2'b00, 16'h5678);
        drain();
        bus.st_ready = 1'b0;
        send(p0, "stall_first");
        bus.tok_valid = 1'b1;
        bus.tok_pkt   = p1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (bus.tok_ready !== 1'b0) begin errors++; $display("FAIL stall_tok_ready[%0d]: got %0b expected 0", i, bus.tok_ready); end
            checks++; if (bus.st_pkt !== p0 || bus.st_valid !== 1'b1) begin errors++; $display("FAIL stall_hold[%0d]: got %0h/%0b expected %0h/1", i, bus.st_pkt, bus.st_valid, p0); end
            checks++; if ({bus.WR_E, bus.DEL} !== 2'b00) begin errors++; $display("FAIL stall_wr_del[%0d]: got %b expected 00", i, {bus.WR_E, bus.DEL}); end
            tick();
        end
        bus.st_ready = 1'b1;
        #1;
        checks++; if (bus.tok_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready: got %0b expected 1", bus.tok_ready); end
        tick();
        bus.tok_valid = 1'b0;
        checks++; if (bus.st_pkt !== p1 || bus.st_valid !== 1'b1) begin errors++; $display("FAIL stall_next_issue: got %0h/%0b expected %0h/1", bus.st_pkt, bus.st_valid, p1); end
        checks++; if (bus.ADDR !== 6'd4) begin errors++; $display("FAIL stall_next_addr: got %0d expected 4", bus.ADDR); end
        tick();
        checks++; if (bus.st_valid !== 1'b0) begin errors++; $display("FAIL stall_drain: got %0b expected 0", bus.st_valid); end
    endtask

    task automatic test_flush();
        int waited;
        drain();
        send(mk(11'h005, 7'd1, 1'b0, 1'b1, 2'b00, 16'h0001), "flush_p1");
        send(mk(11'h005, 7'd2, 1'b1, 1'b1, 2'b00, 16'h0002), "flush_p2");
        send(mk(11'h005, 7'd3, 1'b0, 1'b1, 2'b00, 16'h0003), "flush_p3");
        bus.st_ready = 1'b0;
        checks++; if (occupancy !== 7'd4) begin errors++; $display("FAIL flush_pre_occ: got %0d expected 4", occupancy); end
        flush = 1'b1;
        bus.tok_valid = 1'b1;
        bus.tok_pkt   = mk(11'h006, 7'd8, 1'b0, 1'b1, 2'b00, 16'h0008);
        #1;
        checks++; if (bus.tok_ready !== 1'b0) begin errors++; $display("FAIL flush_wins: got %0b expected 0", bus.tok_ready); end
        tick();
        bus.tok_valid = 1'b0;
        checks++; if (dbg_state !== ST_FLUSH_WAIT || busy !== 1'b1) begin errors++; $display("FAIL flush_wait_state: got %0d/%0b expected %0d/1", dbg_state, busy, ST_FLUSH_WAIT); end
        checks++; if (bus.st_valid !== 1'b1 || bus.ADDR !== 6'd3) begin errors++; $display("FAIL flush_pending_hold: got %0b/%0d expected 1/3", bus.st_valid, bus.ADDR); end
        tick();
        checks++; if (dbg_state !== ST_FLUSH_WAIT) begin errors++; $display("FAIL flush_still_wait: got %0d expected %0d", dbg_state, ST_FLUSH_WAIT); end
        checks++; if (collision !== 1'b1) begin errors++; $display("FAIL flush_coll_held: got %0b expected 1", collision); end
        bus.st_ready = 1'b1;
        tick();
        checks++; if (bus.st_valid !== 1'b0) begin errors++; $display("FAIL flush_handshake: got %0b expected 0", bus.st_valid); end
        tick();
        checks++; if (dbg_state !== ST_INIT) begin errors++; $display("FAIL flush_to_init: got %0d expected %0d", dbg_state, ST_INIT); end
        flush = 1'b0;
        waited = 0;
        while (busy !== 1'b0 && waited < 200) begin
            tick();
            waited++;
        end
        checks++; if (waited !== 64) begin errors++; $display("FAIL flush_init_cycles: got %0d expected 64", waited); end
        checks++; if (occupancy !== 7'd0 || collision !== 1'b0) begin errors++; $display("FAIL flush_cleared: got occ=%0d coll=%0b expected occ=0 coll=0", occupancy, collision); end
        send(mk(11'h007, 7'd1, 1'b1, 1'b1, 2'b00, 16'h0101), "flush_repark");
        checks++; if ({bus.WR_E, bus.DEL} !== 2'b11 || occupancy !== 7'd1) begin errors++; $display("FAIL flush_table_swept: got wr_del=%b occ=%0d expected 11/1", {bus.WR_E, bus.DEL}, occupancy); end
    endtask

    task automatic test_mr_midop();
        int waited;
        drain();
        bus.st_ready = 1'b0;
        send(mk(11'h008, 7'd7, 1'b0, 1'b1, 2'b00, 16'h0707), "mr_park");
        checks++; if (bus.st_valid !== 1'b1 || occupancy !== 7'd2) begin errors++; $display("FAIL mr_pre: got v=%0b occ=%0d expected v=1 occ=2", bus.st_valid, occupancy); end
        MR = 1'b1;
        tick();
        checks++; if ({bus.st_valid, bus.WR_E, bus.DEL} !== 3'b000) begin errors++; $display("FAIL mr_v_wr_del: got %b expected 000", {bus.st_valid, bus.WR_E, bus.DEL}); end
        checks++; if (bus.ADDR !== 6'd0 || bus.st_pkt !== 38'd0) begin errors++; $display("FAIL mr_addr_pkt: got %0d/%0h expected 0/0", bus.ADDR, bus.st_pkt); end
        checks++; if (occupancy !== 7'd0 || collision !== 1'b0) begin errors++; $display("FAIL mr_occ_coll: got %0d/%0b expected 0/0", occupancy, collision); end
        checks++; if (busy !== 1'b1 || bus.tok_ready !== 1'b0) begin errors++; $display("FAIL mr_busy_ready: got %0b/%0b expected 1/0", busy, bus.tok_ready); end
        MR = 1'b0;
        bus.st_ready = 1'b1;
        waited = 0;
        while (busy !== 1'b0 && waited < 200) begin
            tick();
            waited++;
        end
        checks++; if (waited !== 64) begin errors++; $display("FAIL mr_init_cycles: got %0d expected 64", waited); end
        send(mk(11'h009, 7'd7, 1'b0, 1'b1, 2'b00, 16'h0708), "mr_repark");
        checks++; if ({bus.WR_E, bus.DEL} !== 2'b11 || occupancy !== 7'd1 || collision !== 1'b0) begin errors++; $display("FAIL mr_table_swept: got wr_del=%b occ=%0d coll=%0b expected 11/1/0", {bus.WR_E, bus.DEL}, occupancy, collision); end
    endtask

    initial begin
        MR            = 1'b1;
        flush         = 1'b0;
        bus.tok_valid = 1'b0;
        bus.tok_pkt   = '0;
        bus.st_ready  = 1'b1;
        test_reset();
        test_match();
        test_collision();
        test_stall();
        test_flush();
        test_mr_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
